soc_cpu_4_oci_dct_packer: RTL and testbench
===========================================

SOC_CPU_4_OCI_DCT_PACKER -- requirements
Module: soc_cpu_4_oci_dct_packer

Interface
REQ-001 SHALL have parameter FLUSH_TIMEOUT, default 255, meaning idle cycles with a partial frame before an automatic flush (legal range 1..255).
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all logic updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port sym_valid, input, 1 bit: a trace symbol is offered.
REQ-005 SHALL have port sym_data, input, 2 bits: the trace symbol.
REQ-006 SHALL have port sym_ready, output, 1 bit: the packer accepts the symbol this cycle.
REQ-007 SHALL have port flush, input, 1 bit: request to emit the partial frame.
REQ-008 SHALL have port test_end_req, input, 1 bit: request to close the trace session.
REQ-009 SHALL have port dct_buffer, output, 30 bits: packed symbols, newest in bits [1:0].
REQ-010 SHALL have port dct_count, output, 4 bits: number of valid symbols in dct_buffer (0..15).
REQ-011 SHALL have port frame_valid, output, 1 bit: dct_buffer/dct_count hold a complete frame.
REQ-012 SHALL have port frame_ready, input, 1 bit: the consumer takes the frame.
REQ-013 SHALL have port test_ending, output, 1 bit: session close in progress.
REQ-014 SHALL have port test_has_ended, output, 1 bit: session closed and all trace delivered.

Function
REQ-015 SHALL implement states ACCUM, OUT, DONE; all outputs registered except sym_ready.
REQ-016 SHALL drive sym_ready = 1 only in ACCUM with no end pending; a symbol is accepted on sym_valid & sym_ready.
REQ-017 SHALL, on accept, shift: dct_buffer <= {dct_buffer[27:0], sym_data}, dct_count <= dct_count + 1.
REQ-018 SHALL, on the accept that makes dct_count 15, enter OUT the next cycle (frame_valid = 1 that cycle).
REQ-019 SHALL, on flush in ACCUM with dct_count > 0 or an accept this cycle, include any same-cycle symbol, then enter OUT.
REQ-020 SHALL ignore flush when dct_count = 0 and no accept occurs.
REQ-021 SHALL keep an 8-bit idle counter: cleared on accept or on leaving ACCUM, incremented each ACCUM cycle with dct_count > 0 and no accept; on reaching FLUSH_TIMEOUT, SHALL enter OUT.
REQ-022 SHALL hold dct_buffer, dct_count, frame_valid stable in OUT until frame_ready.
REQ-023 SHALL, on frame_valid & frame_ready, clear dct_buffer and dct_count to 0, deassert frame_valid next cycle, go to ACCUM (or DONE if end pending).
REQ-024 SHALL never drop a symbol; back-pressure via sym_ready only.
REQ-025 SHALL latch test_end_req (level or one-cycle pulse) into end_pending; test_ending = 1 from the cycle after the latch until reset.
REQ-026 SHALL, with end_pending in ACCUM: if dct_count > 0, enter OUT; else enter DONE.
REQ-027 SHALL, with test_end_req and an accept in the same cycle, include that symbol in the final frame.
REQ-028 SHALL in DONE drive test_has_ended = 1, test_ending = 1, sym_ready = 0, frame_valid = 0; DONE exits only on reset.
REQ-029 SHALL treat flush and timeout in OUT or DONE as no-ops.

Reset
REQ-030 SHALL, while reset = 1 at a clock edge, set state ACCUM, dct_buffer = 0, dct_count = 0, frame_valid = 0, test_ending = 0, test_has_ended = 0, end_pending = 0, idle counter = 0.
REQ-031 SHALL give reset priority over all other inputs, including mid-frame in OUT (frame discarded).
REQ-032 SHALL drive sym_ready = 0 during the reset cycle.

Verification
REQ-033 Full frame: 15 accepted symbols 2'b01, frame_ready = 1 -> frame_valid one cycle after the 15th accept, dct_buffer = 30'h15555555, dct_count = 15, then 0/0.
REQ-034 Partial flush: 3 symbols 2'b11, 2'b00, 2'b10, then flush -> dct_buffer = 30'h00000032, dct_count = 3, frame_valid = 1.
REQ-035 Timeout: FLUSH_TIMEOUT = 4, one symbol 2'b10, no activity -> frame_valid = 1 after 4 idle cycles, dct_count = 1.
REQ-036 Back-pressure: frame_ready = 0 for 10 cycles in OUT with sym_valid = 1 -> sym_ready = 0, outputs stable, no symbol lost after release.
REQ-037 End sequence: 2 symbols, then test_end_req pulse -> test_ending = 1, final frame dct_count = 2, after handshake test_has_ended = 1 and sym_ready = 0 held.
REQ-038 Reset in OUT: reset asserted while frame_valid = 1 -> next cycle all outputs zero, state ACCUM, sym_ready = 1.

Source files
------------

// File: rtl/soc_cpu_4_oci_dct_packer.sv
// Trace symbol packer: gathers up to 15 two-bit symbols into a 30-bit frame and
// hands it to a consumer, with flush, idle timeout and session-close handling.
module soc_cpu_4_oci_dct_packer #(
  parameter int unsigned FLUSH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sym_valid,
  input  logic [1:0]  sym_data,
  output logic        sym_ready,
  input  logic        flush,
  input  logic        test_end_req,
  output logic [29:0] dct_buffer,
  output logic [3:0]  dct_count,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic        test_ending,
  output logic        test_has_ended
);

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    OUT   = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [7:0] TIMEOUT = 8'(FLUSH_TIMEOUT);
  localparam logic [3:0] FULL    = 4'd15;

  state_e      state_q;
  logic [29:0] buf_q;
  logic [3:0]  count_q;
  logic        frame_valid_q;
  logic        end_pending_q;
  logic        test_ending_q;
  logic        test_has_ended_q;
  logic [7:0]  idle_q;

  logic        accept;
  logic [29:0] buf_d;
  logic [3:0]  count_d;
  logic [7:0]  idle_d;

  // sym_ready is the one combinational output so a symbol can be taken in the
  // same cycle it is offered; it is forced low while reset is applied.
  assign sym_ready = (state_q == ACCUM) && !end_pending_q && !reset;
  assign accept    = sym_valid && sym_ready;
  assign buf_d     = {buf_q[27:0], sym_data};
  assign count_d   = count_q + 4'd1;
  assign idle_d    = idle_q + 8'd1;

  // NOTE: every register here uses non-blocking assignments so all state updates
  // see the pre-edge values; mixing in blocking writes would create ordering races.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= ACCUM;
      buf_q            <= '0;
      count_q          <= '0;
      frame_valid_q    <= 1'b0;
      end_pending_q    <= 1'b0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
      idle_q           <= '0;
    end else begin
      if (test_end_req) begin
        end_pending_q <= 1'b1;
        test_ending_q <= 1'b1;
      end

      unique case (state_q)
        ACCUM: begin
          if (accept) begin
            buf_q   <= buf_d;
            count_q <= count_d;
            idle_q  <= '0;
          end

          if (end_pending_q) begin
            // No symbol can be accepted here, so count_q is the final frame size.
            idle_q <= '0;
            if (count_q != 4'd0) begin
              state_q       <= OUT;
              frame_valid_q <= 1'b1;
            end else begin
              state_q          <= DONE;
              test_has_ended_q <= 1'b1;
            end
          end else if (accept) begin
            if (count_d == FULL || flush) begin
              state_q       <= OUT;
              frame_valid_q <= 1'b1;
            end
          end else if (count_q != 4'd0) begin
            if (flush || idle_d == TIMEOUT) begin
              state_q       <= OUT;
              frame_valid_q <= 1'b1;
              idle_q        <= '0;
            end else begin
              idle_q <= idle_d;
            end
          end
        end

        OUT: begin
          if (frame_ready) begin
            buf_q         <= '0;
            count_q       <= '0;
            frame_valid_q <= 1'b0;
            if (end_pending_q || test_end_req) begin
              state_q          <= DONE;
              test_has_ended_q <= 1'b1;
            end else begin
              state_q <= ACCUM;
            end
          end
        end

        DONE: begin
          frame_valid_q <= 1'b0;
        end

        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign dct_buffer     = buf_q;
  assign dct_count      = count_q;
  assign frame_valid    = frame_valid_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule

// File: tb/tb_soc_cpu_4_oci_dct_packer.sv
// Bench for the trace symbol packer: table of frames plus hand-written corner
// sequences; completed frames are checked against a scoreboard queue.
module tb_soc_cpu_4_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sym_valid;
  logic [1:0]  sym_data;
  logic        sym_ready;
  logic        flush;
  logic        test_end_req;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        frame_valid;
  logic        frame_ready;
  logic        test_ending;
  logic        test_has_ended;

  soc_cpu_4_oci_dct_packer #(.FLUSH_TIMEOUT(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .sym_valid      (sym_valid),
    .sym_data       (sym_data),
    .sym_ready      (sym_ready),
    .flush          (flush),
    .test_end_req   (test_end_req),
    .dct_buffer     (dct_buffer),
    .dct_count      (dct_count),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .test_ending    (test_ending),
    .test_has_ended (test_has_ended)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [29:0] buf_v;
    logic [3:0]  cnt;
  } frame_t;

  typedef struct packed {
    logic [4:0]       n;
    logic [14:0][1:0] syms;
    logic             flush_close;
    logic             flush_with_last;
    logic [29:0]      exp_buf;
    logic [3:0]       exp_cnt;
  } vec_t;

  frame_t sb_q[$];
  frame_t sb_e;
  vec_t   vecs[7];
  int     n_checks = 0;
  int     n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [29:0] b, input logic [3:0] c);
    frame_t f;
    f.buf_v = b;
    f.cnt   = c;
    sb_q.push_back(f);
  endtask

  task automatic do_reset();
    reset        = 1'b1;
    sym_valid    = 1'b0;
    sym_data     = 2'b00;
    flush        = 1'b0;
    test_end_req = 1'b0;
    frame_ready  = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: every handshaken frame must match the oldest expected frame.
  always @(negedge clk) begin
    if (!reset && frame_valid && frame_ready) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected: got frame %0h/%0d expected none", dct_buffer, dct_count);
      end else begin
        sb_e = sb_q.pop_front();
        check("sb_buf", {2'b00, dct_buffer}, {2'b00, sb_e.buf_v});
        check("sb_cnt", {28'd0, dct_count}, {28'd0, sb_e.cnt});
      end
    end
  end

  task automatic run_vec(input int idx, input vec_t v);
    push_frame(v.exp_buf, v.exp_cnt);
    frame_ready = 1'b1;
    for (int i = 0; i < int'(v.n); i++) begin
      sym_valid = 1'b1;
      sym_data  = v.syms[i];
      flush     = v.flush_with_last && (i == int'(v.n) - 1);
      #1 check($sformatf("vec%0d_ready%0d", idx, i), {31'd0, sym_ready}, 32'd1);
      tick();
    end
    sym_valid = 1'b0;
    flush     = 1'b0;
    if (v.flush_close && !v.flush_with_last) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
    end
    check($sformatf("vec%0d_fv", idx), {31'd0, frame_valid}, 32'd1);
    check($sformatf("vec%0d_ready_out", idx), {31'd0, sym_ready}, 32'd0);
    tick();
    check($sformatf("vec%0d_fv_clr", idx), {31'd0, frame_valid}, 32'd0);
    check($sformatf("vec%0d_cnt_clr", idx), {28'd0, dct_count}, 32'd0);
    check($sformatf("vec%0d_buf_clr", idx), {2'b00, dct_buffer}, 32'd0);
  endtask

  task automatic send(input logic [1:0] d, input string name);
    sym_valid = 1'b1;
    sym_data  = d;
    #1 check(name, {31'd0, sym_ready}, 32'd1);
    tick();
    sym_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int idle;

    vecs[0] = '{n: 5'd15, syms: '0, flush_close: 1'b0, flush_with_last: 1'b0,
                exp_buf: 30'h15555555, exp_cnt: 4'd15};
    vecs[1] = '{n: 5'd3, syms: '0, flush_close: 1'b1, flush_with_last: 1'b0,
                exp_buf: 30'h00000032, exp_cnt: 4'd3};
    vecs[2] = '{n: 5'd15, syms: '0, flush_close: 1'b0, flush_with_last: 1'b0,
                exp_buf: 30'h3FFFFFFF, exp_cnt: 4'd15};
    vecs[3] = '{n: 5'd1, syms: '0, flush_close: 1'b1, flush_with_last: 1'b0,
                exp_buf: 30'h00000002, exp_cnt: 4'd1};
    vecs[4] = '{n: 5'd4, syms: '0, flush_close: 1'b1, flush_with_last: 1'b0,
                exp_buf: 30'h0000001B, exp_cnt: 4'd4};
    vecs[5] = '{n: 5'd15, syms: '0, flush_close: 1'b0, flush_with_last: 1'b0,
                exp_buf: 30'h06C6C6C6, exp_cnt: 4'd15};
    vecs[6] = '{n: 5'd2, syms: '0, flush_close: 1'b1, flush_with_last: 1'b1,
                exp_buf: 30'h00000007, exp_cnt: 4'd2};
    for (int i = 0; i < 15; i++) begin
      vecs[0].syms[i] = 2'b01;
      vecs[2].syms[i] = 2'b11;
      vecs[5].syms[i] = 2'(i % 4);
    end
    vecs[1].syms[0] = 2'b11;
    vecs[1].syms[1] = 2'b00;
    vecs[1].syms[2] = 2'b10;
    vecs[3].syms[0] = 2'b10;
    for (int i = 0; i < 4; i++) vecs[4].syms[i] = 2'(i);
    vecs[6].syms[0] = 2'b01;
    vecs[6].syms[1] = 2'b11;

    // Reset state, including sym_ready held low while reset is high.
    reset        = 1'b1;
    sym_valid    = 1'b1;
    sym_data     = 2'b01;
    flush        = 1'b0;
    test_end_req = 1'b0;
    frame_ready  = 1'b1;
    tick();
    tick();
    check("rst_ready", {31'd0, sym_ready}, 32'd0);
    check("rst_buf", {2'b00, dct_buffer}, 32'd0);
    check("rst_cnt", {28'd0, dct_count}, 32'd0);
    check("rst_fv", {31'd0, frame_valid}, 32'd0);
    check("rst_ending", {31'd0, test_ending}, 32'd0);
    check("rst_ended", {31'd0, test_has_ended}, 32'd0);
    sym_valid = 1'b0;
    reset     = 1'b0;
    #1 check("rst_release_ready", {31'd0, sym_ready}, 32'd1);

    for (int v = 0; v < 7; v++) run_vec(v, vecs[v]);

    // Idle timeout: one symbol, then exactly four idle cycles to the frame.
    push_frame(30'h2, 4'd1);
    send(2'b10, "to_ready");
    idle = 0;
    while (!frame_valid && idle < 10) begin
      tick();
      idle++;
    end
    check("to_idle_cycles", idle, 32'd4);
    check("to_cnt", {28'd0, dct_count}, 32'd1);
    tick();
    check("to_fv_clr", {31'd0, frame_valid}, 32'd0);

    // Back-pressure: frame held for 10 cycles while a symbol waits.
    frame_ready = 1'b0;
    send(2'b01, "bp_ready0");
    send(2'b10, "bp_ready1");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    push_frame(30'h6, 4'd2);
    sym_valid = 1'b1;
    sym_data  = 2'b11;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("bp_hold_ready%0d", i), {31'd0, sym_ready}, 32'd0);
      check($sformatf("bp_hold_fv%0d", i), {31'd0, frame_valid}, 32'd1);
      check($sformatf("bp_hold_buf%0d", i), {2'b00, dct_buffer}, 32'h6);
      check($sformatf("bp_hold_cnt%0d", i), {28'd0, dct_count}, 32'd2);
      tick();
    end
    frame_ready = 1'b1;
    tick();
    push_frame(30'h3, 4'd1);
    #1 check("bp_release_ready", {31'd0, sym_ready}, 32'd1);
    tick();
    sym_valid = 1'b0;
    flush     = 1'b1;
    tick();
    flush = 1'b0;
    check("bp_last_fv", {31'd0, frame_valid}, 32'd1);
    tick();

    // Reset while a frame is waiting in OUT discards it.
    frame_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(2'b11, "ro_ready");
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("ro_fv", {31'd0, frame_valid}, 32'd1);
    reset = 1'b1;
    #1 check("ro_rst_ready", {31'd0, sym_ready}, 32'd0);
    tick();
    reset = 1'b0;
    #1;
    check("ro_fv_clr", {31'd0, frame_valid}, 32'd0);
    check("ro_buf_clr", {2'b00, dct_buffer}, 32'd0);
    check("ro_cnt_clr", {28'd0, dct_count}, 32'd0);
    check("ro_ending", {31'd0, test_ending}, 32'd0);
    check("ro_ready", {31'd0, sym_ready}, 32'd1);
    frame_ready = 1'b1;

    // Session end: two symbols, then a one-cycle close request.
    push_frame(30'h7, 4'd2);
    send(2'b01, "end_ready0");
    send(2'b11, "end_ready1");
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    check("end_ending", {31'd0, test_ending}, 32'd1);
    check("end_ready_blocked", {31'd0, sym_ready}, 32'd0);
    check("end_not_ended", {31'd0, test_has_ended}, 32'd0);
    idle = 0;
    while (!test_has_ended && idle < 8) begin
      tick();
      idle++;
    end
    check("end_ended", {31'd0, test_has_ended}, 32'd1);
    sym_valid = 1'b1;
    flush     = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("done_ready%0d", i), {31'd0, sym_ready}, 32'd0);
      check($sformatf("done_fv%0d", i), {31'd0, frame_valid}, 32'd0);
      check($sformatf("done_ending%0d", i), {31'd0, test_ending}, 32'd1);
      check($sformatf("done_ended%0d", i), {31'd0, test_has_ended}, 32'd1);
      tick();
    end

    // Close request in the same cycle as an accept keeps that symbol.
    do_reset();
    push_frame(30'h2, 4'd1);
    sym_valid    = 1'b1;
    sym_data     = 2'b10;
    test_end_req = 1'b1;
    #1 check("same_cycle_ready", {31'd0, sym_ready}, 32'd1);
    tick();
    sym_valid    = 1'b0;
    test_end_req = 1'b0;
    idle = 0;
    while (!test_has_ended && idle < 8) begin
      tick();
      idle++;
    end
    check("same_cycle_ended", {31'd0, test_has_ended}, 32'd1);

    // Close request with nothing buffered goes straight to DONE, no frame.
    do_reset();
    test_end_req = 1'b1;
    tick();
    test_end_req = 1'b0;
    tick();
    check("empty_end_ended", {31'd0, test_has_ended}, 32'd1);
    check("empty_end_fv", {31'd0, frame_valid}, 32'd0);
    tick();

    check("sb_drained", sb_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
